// File: rtl/cmp_stim_sequencer.sv
// ============================================================================
// Module   : cmp_stim_sequencer
// Brief    : Drives A/B stimulus to a 4-bit comparator, scores its R_in result.
//            Define CMP_SEQ_EXHAUSTIVE_EN for all 256 pairs instead of 10 fixed.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_stim_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] R_in,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [8:0] pass_count,
  output logic [8:0] fail_count,
  output logic       fail_flag,
  output logic [7:0] first_fail_idx
);

`ifdef CMP_SEQ_EXHAUSTIVE_EN
  localparam int NUM_VEC = 256;
`else
  localparam int NUM_VEC = 10;
`endif
  localparam logic [7:0] LAST_IDX    = 8'(NUM_VEC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Returns {A, B} for vector index idx.
  function automatic logic [7:0] vec_ab(input logic [7:0] idx);
`ifdef CMP_SEQ_EXHAUSTIVE_EN
    return idx;
`else
    case (idx)
      8'd0:    return 8'h52;
      8'd1:    return 8'hCC;
      8'd2:    return 8'h25;
      8'd3:    return 8'hAC;
      8'd4:    return 8'hF0;
      8'd5:    return 8'h55;
      8'd6:    return 8'h0F;
      8'd7:    return 8'h87;
      8'd8:    return 8'h33;
      8'd9:    return 8'hDA;
      default: return 8'h00;
    endcase
`endif
  endfunction

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic       done_q, done_d;
  logic [8:0] pass_q, pass_d;
  logic [8:0] fail_q, fail_d;
  logic       flag_q, flag_d;
  logic [7:0] ffi_q, ffi_d;

  logic [2:0] expected;
  logic [7:0] cur_vec;

  assign expected = {a_q > b_q, a_q == b_q, a_q < b_q};
  assign cur_vec  = vec_ab(idx_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    done_d   = done_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    flag_d   = flag_q;
    ffi_d    = ffi_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 8'd0;
          done_d  = 1'b0;
          pass_d  = 9'd0;
          fail_d  = 9'd0;
          flag_d  = 1'b0;
          ffi_d   = 8'd0;
        end
      end
      DRIVE: begin
        a_d      = cur_vec[7:4];
        b_d      = cur_vec[3:0];
        settle_d = 4'd0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      CHECK: begin
        // Anything but the exact one-hot code (incl. 000, multi-hot) fails.
        if (R_in == expected) begin
          pass_d = pass_q + 9'd1;
        end else begin
          fail_d = fail_q + 9'd1;
          if (!flag_q) begin
            flag_d = 1'b1;
            ffi_d  = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      idx_q    <= 8'd0;
      settle_q <= 4'd0;
      done_q   <= 1'b0;
      pass_q   <= 9'd0;
      fail_q   <= 9'd0;
      flag_q   <= 1'b0;
      ffi_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      flag_q   <= flag_d;
      ffi_q    <= ffi_d;
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign busy           = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done           = done_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign fail_flag      = flag_q;
  assign first_fail_idx = ffi_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_stim_sequencer.sv
// ============================================================================
// Module   : tb_cmp_stim_sequencer
// Brief    : Self-checking bench: a faultable comparator model plus scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmp_stim_sequencer;

  localparam int S = 2;
`ifdef CMP_SEQ_EXHAUSTIVE_EN
  localparam int NV = 256;
`else
  localparam int NV = 10;
`endif
  localparam int PERIOD = S + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] r_in;
  logic [3:0] a, b;
  logic       busy, done;
  logic [8:0] pass_count, fail_count;
  logic       fail_flag;
  logic [7:0] first_fail_idx;

  // Per-(A,B) corruption applied on top of an ideal comparator.
  logic [2:0] mask [256];

  int n_checks = 0;
  int n_pass   = 0;

  int va_tab [10] = '{5, 12, 2, 10, 15, 5, 0, 8, 3, 13};
  int vb_tab [10] = '{2, 12, 5, 12, 0, 5, 15, 7, 3, 10};

  always #5 clk = ~clk;

  function automatic logic [2:0] golden(input logic [3:0] x, input logic [3:0] y);
    return {x > y, x == y, x < y};
  endfunction

  assign r_in = golden(a, b) ^ mask[{a, b}];

  cmp_stim_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .R_in           (r_in),
    .A              (a),
    .B              (b),
    .busy           (busy),
    .done           (done),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .fail_flag      (fail_flag),
    .first_fail_idx (first_fail_idx)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int vec_a(input int i);
`ifdef CMP_SEQ_EXHAUSTIVE_EN
    return i / 16;
`else
    return va_tab[i];
`endif
  endfunction

  function automatic int vec_b(input int i);
`ifdef CMP_SEQ_EXHAUSTIVE_EN
    return i % 16;
`else
    return vb_tab[i];
`endif
  endfunction

  // mode 0: ideal, 1: R_in stuck 000, 2: eq bit stuck 0, 3: random faults
  task automatic set_faults(input int mode);
    for (int k = 0; k < 256; k++) begin
      logic [2:0] g;
      g = golden(4'(k / 16), 4'(k % 16));
      case (mode)
        1:       mask[k] = g;
        2:       mask[k] = g & 3'b010;
        3:       mask[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        default: mask[k] = 3'b000;
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    int'(a), 0);
    check({tag, "_b"},    int'(b), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass_count), 0);
    check({tag, "_fail"}, int'(fail_count), 0);
    check({tag, "_flag"}, int'(fail_flag), 0);
    check({tag, "_ffi"},  int'(first_fail_idx), 0);
  endtask

  // Start a run, optionally re-pulse start mid-run, then score it.
  task automatic run_and_check(input string tag, input bit pulse_mid);
    int cycles, exp_pass, exp_fail, exp_ffi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_at_start"}, int'(busy), 1);
    cycles = 0;
    while (!done && cycles < NV * PERIOD + 50) begin
      start = pulse_mid && (cycles == 4 * PERIOD + 1);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    exp_pass = 0; exp_fail = 0; exp_ffi = -1;
    for (int i = 0; i < NV; i++) begin
      if (mask[vec_a(i) * 16 + vec_b(i)] == 3'b000) exp_pass++;
      else begin
        exp_fail++;
        if (exp_ffi < 0) exp_ffi = i;
      end
    end
    check({tag, "_cycles"}, cycles, NV * PERIOD);
    check({tag, "_done"},   int'(done), 1);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_pass"},   int'(pass_count), exp_pass);
    check({tag, "_fail"},   int'(fail_count), exp_fail);
    check({tag, "_flag"},   int'(fail_flag), (exp_fail > 0) ? 1 : 0);
    check({tag, "_ffi"},    int'(first_fail_idx), (exp_ffi < 0) ? 0 : exp_ffi);
    check({tag, "_last_a"}, int'(a), vec_a(NV - 1));
    check({tag, "_last_b"}, int'(b), vec_b(NV - 1));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    set_faults(0);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);

    set_faults(0);
    run_and_check("ideal", 1'b0);

    // A and B must hold while sitting in DONE.
    repeat (5) @(posedge clk);
    #1;
    check("hold_a", int'(a), vec_a(NV - 1));
    check("hold_b", int'(b), vec_b(NV - 1));
    check("hold_done", int'(done), 1);

    set_faults(1);
    run_and_check("tied0", 1'b0);

    set_faults(2);
    run_and_check("eq_stuck", 1'b0);

    set_faults(0);
    run_and_check("mid_start", 1'b1);

    // Abort part-way through vector 6 with start also asserted.
    set_faults(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6 * PERIOD + 1) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check_all_zero("abort");
    @(posedge clk); #1;
    check("abort_stays_idle", int'(busy), 0);
    set_faults(0);
    run_and_check("after_abort", 1'b0);

    for (int r = 0; r < 4; r++) begin
      set_faults(3);
      run_and_check($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
